// File: rtl/ram_arbiter_pkg.sv
// Shared types and default widths for the RAM port arbiter.
// Covers the CPU pass-through path and the halted external-requester access sequence.
package ram_arbiter_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_MAX_BURST   = 16;

    typedef enum logic [2:0] {
        ST_CPU    = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the CPU control path and one external requester.
// The CPU is halted only at instruction boundaries, and a burst limit forces the port back to it.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic              i_nclk,
    input  logic              i_reset,
    input  logic              i_instrFinishedN,
    output logic              o_halt,
    input  logic [ADDR_W-1:0] i_cpuRamAddr,
    input  logic [DATA_W-1:0] i_cpuRamData,
    input  logic              i_cpuRamNWE,
    input  logic              i_cpuRamNOE,
    output logic [ADDR_W-1:0] o_ramAddr,
    output logic [DATA_W-1:0] o_ramData,
    output logic              o_ramNWE,
    output logic              o_ramNOE,
    input  logic [DATA_W-1:0] i_ramData,
    input  logic              i_dmaReq,
    output logic              o_dmaGrant,
    input  logic              i_dmaValid,
    output logic              o_dmaReady,
    input  logic              i_dmaWrite,
    input  logic [ADDR_W-1:0] i_dmaAddr,
    input  logic [DATA_W-1:0] i_dmaWdata,
    output logic [DATA_W-1:0] o_dmaRdata,
    output logic              o_dmaDone
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int WAIT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t              state_r;
    state_t              state_s;
    logic [BURST_W-1:0]  burst_r;
    logic [WAIT_W-1:0]   wait_r;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [DATA_W-1:0]   lat_data_r;
    logic                lat_write_r;
    logic                halt_r;
    logic                grant_r;
    logic                first_cpu_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                last_wait_s;
    logic                burst_full_s;

    assign last_wait_s  = (wait_r == WAIT_W'(WAIT_CYCLES - 1));
    assign burst_full_s = ((burst_r + BURST_W'(1)) == BURST_W'(MAX_BURST));

    // Next-state decode; the first CPU cycle after a release ignores the instruction boundary.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CPU: begin
                if (i_dmaReq && !i_instrFinishedN && !first_cpu_r) state_s = ST_GRANT;
                else                                               state_s = ST_CPU;
            end
            ST_GRANT: begin
                if (i_dmaValid)     state_s = ST_SETUP;
                else if (!i_dmaReq) state_s = ST_CPU;
                else                state_s = ST_GRANT;
            end
            ST_SETUP: state_s = ST_STROBE;
            ST_STROBE: begin
                if (last_wait_s) state_s = ST_HOLD;
                else             state_s = ST_STROBE;
            end
            ST_HOLD: begin
                if (burst_full_s || !i_dmaReq) state_s = ST_CPU;
                else                           state_s = ST_GRANT;
            end
            default: state_s = ST_CPU;
        endcase
    end

    // State, halt/grant and wait-state counter registers.
    always_ff @(posedge i_nclk) begin
        if (i_reset) begin
            state_r     <= ST_CPU;
            halt_r      <= 1'b0;
            grant_r     <= 1'b0;
            first_cpu_r <= 1'b0;
            wait_r      <= '0;
        end else begin
            state_r     <= state_s;
            halt_r      <= (state_s != ST_CPU);
            grant_r     <= (state_s != ST_CPU);
            first_cpu_r <= (state_s == ST_CPU) && (state_r != ST_CPU);
            if (state_r == ST_STROBE) wait_r <= wait_r + WAIT_W'(1);
            else                      wait_r <= '0;
        end
    end

    // Burst counting, request latching and read-data capture.
    always_ff @(posedge i_nclk) begin
        if (i_reset) begin
            burst_r     <= '0;
            lat_addr_r  <= '0;
            lat_data_r  <= '0;
            lat_write_r <= 1'b0;
            rdata_r     <= '0;
        end else begin
            if (state_r == ST_CPU && state_s == ST_GRANT)
                burst_r <= '0;
            else if (state_r == ST_HOLD && burst_r != BURST_W'(MAX_BURST))
                burst_r <= burst_r + BURST_W'(1);
            else
                burst_r <= burst_r;

            if (state_r == ST_GRANT && i_dmaValid) begin
                lat_addr_r  <= i_dmaAddr;
                lat_data_r  <= i_dmaWdata;
                lat_write_r <= i_dmaWrite;
            end else begin
                lat_addr_r  <= lat_addr_r;
                lat_data_r  <= lat_data_r;
                lat_write_r <= lat_write_r;
            end

            if (state_r == ST_STROBE && last_wait_s && !lat_write_r) rdata_r <= i_ramData;
            else                                                   rdata_r <= rdata_r;
        end
    end

    // RAM port mux: CPU passes straight through, otherwise latched requester access.
    always_comb begin
        if (state_r == ST_CPU) begin
            o_ramAddr = i_cpuRamAddr;
            o_ramData = i_cpuRamData;
            o_ramNWE  = i_cpuRamNWE;
            o_ramNOE  = i_cpuRamNOE;
        end else begin
            o_ramAddr = lat_addr_r;
            o_ramData = lat_data_r;
            o_ramNWE  = !((state_r == ST_STROBE) && lat_write_r);
            o_ramNOE  = !((state_r == ST_STROBE) && !lat_write_r);
        end
    end

    assign o_halt     = halt_r;
    assign o_dmaGrant = grant_r;
    assign o_dmaReady = (state_r == ST_GRANT);
    assign o_dmaDone  = (state_r == ST_HOLD);
    assign o_dmaRdata = rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (1 and 3 wait states) share stimulus,
// one is selected per scenario, and completed accesses are checked against a queue of expectations.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifn;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_nwe;
    logic        cpu_noe;
    logic [7:0]  ram_data;
    logic        dma_req;
    logic        dma_valid;
    logic        dma_write;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        sel;

    logic        halt1, grant1, ready1, done1, nwe1, noe1;
    logic [15:0] addr1;
    logic [7:0]  data1, rdata1;
    logic        halt3, grant3, ready3, done3, nwe3, noe3;
    logic [15:0] addr3;
    logic [7:0]  data3, rdata3;

    logic        obs_halt, obs_grant, obs_ready, obs_done, obs_nwe, obs_noe;
    logic [15:0] obs_addr;
    logic [7:0]  obs_data, obs_rdata;

    typedef struct {
        bit         wr;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_model(input logic [15:0] a);
        if (a == 16'h0042) return 8'h5A;
        else               return a[7:0] ^ 8'h3C;
    endfunction

    assign obs_halt  = sel ? halt3  : halt1;
    assign obs_grant = sel ? grant3 : grant1;
    assign obs_ready = sel ? ready3 : ready1;
    assign obs_done  = sel ? done3  : done1;
    assign obs_nwe   = sel ? nwe3   : nwe1;
    assign obs_noe   = sel ? noe3   : noe1;
    assign obs_addr  = sel ? addr3  : addr1;
    assign obs_data  = sel ? data3  : data1;
    assign obs_rdata = sel ? rdata3 : rdata1;
    assign ram_data  = ram_model(obs_addr);

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1), .MAX_BURST(4)) u1 (
        .i_nclk(clk), .i_reset(rst), .i_instrFinishedN(ifn), .o_halt(halt1),
        .i_cpuRamAddr(cpu_addr), .i_cpuRamData(cpu_data), .i_cpuRamNWE(cpu_nwe), .i_cpuRamNOE(cpu_noe),
        .o_ramAddr(addr1), .o_ramData(data1), .o_ramNWE(nwe1), .o_ramNOE(noe1), .i_ramData(ram_data),
        .i_dmaReq(dma_req), .o_dmaGrant(grant1), .i_dmaValid(dma_valid), .o_dmaReady(ready1),
        .i_dmaWrite(dma_write), .i_dmaAddr(dma_addr), .i_dmaWdata(dma_wdata),
        .o_dmaRdata(rdata1), .o_dmaDone(done1)
    );

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3), .MAX_BURST(16)) u3 (
        .i_nclk(clk), .i_reset(rst), .i_instrFinishedN(ifn), .o_halt(halt3),
        .i_cpuRamAddr(cpu_addr), .i_cpuRamData(cpu_data), .i_cpuRamNWE(cpu_nwe), .i_cpuRamNOE(cpu_noe),
        .o_ramAddr(addr3), .o_ramData(data3), .o_ramNWE(nwe3), .o_ramNOE(noe3), .i_ramData(ram_data),
        .i_dmaReq(dma_req), .o_dmaGrant(grant3), .i_dmaValid(dma_valid), .o_dmaReady(ready3),
        .i_dmaWrite(dma_write), .i_dmaAddr(dma_addr), .i_dmaWdata(dma_wdata),
        .o_dmaRdata(rdata3), .o_dmaDone(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, and retire any completed access.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (obs_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                if (!e.wr) chk("dma_rdata", {24'd0, obs_rdata}, {24'd0, e.rdata});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb.delete();
        done_cnt = 0;
    endtask

    task automatic do_grant();
        dma_req = 1'b1;
        ifn = 1'b0;
        step();
        ifn = 1'b1;
        chk("grant_halt", {31'd0, obs_halt}, 32'd1);
        chk("grant_ready", {31'd0, obs_ready}, 32'd1);
    endtask

    task automatic access(input bit w, input logic [15:0] a, input logic [7:0] wd, input bit drop_req,
                          output int lat, output int nwe_lo, output int noe_lo);
        int start;
        dma_write = w;
        dma_addr = a;
        dma_wdata = wd;
        dma_valid = 1'b1;
        chk("ready_at_accept", {31'd0, obs_ready}, 32'd1);
        sb.push_back('{w, ram_model(a)});
        start = done_cnt;
        nwe_lo = 0;
        noe_lo = 0;
        step();
        dma_valid = 1'b0;
        if (drop_req) dma_req = 1'b0;
        lat = 1;
        while (done_cnt == start && lat < 30) begin
            chk("access_addr", {16'd0, obs_addr}, {16'd0, a});
            if (w) chk("access_wdata", {24'd0, obs_data}, {24'd0, wd});
            nwe_lo += (obs_nwe == 1'b0) ? 1 : 0;
            noe_lo += (obs_noe == 1'b0) ? 1 : 0;
            step();
            lat++;
        end
        chk("done_seen", done_cnt - start, 32'd1);
        chk("hold_addr", {16'd0, obs_addr}, {16'd0, a});
        chk("hold_strobes", {30'd0, obs_nwe, obs_noe}, 32'd3);
    endtask

    initial begin
        int lat, nwe_lo, noe_lo, d0, cyc;
        rst = 1'b1; ifn = 1'b1; sel = 1'b0;
        cpu_addr = 16'hBEEF; cpu_data = 8'h11; cpu_nwe = 1'b1; cpu_noe = 1'b0;
        dma_req = 1'b0; dma_valid = 1'b0; dma_write = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0;

        // Reset state and CPU pass-through
        do_reset();
        chk("rst_halt", {31'd0, obs_halt}, 32'd0);
        chk("rst_grant", {31'd0, obs_grant}, 32'd0);
        chk("rst_ready", {31'd0, obs_ready}, 32'd0);
        chk("rst_done", {31'd0, obs_done}, 32'd0);
        chk("rst_rdata", {24'd0, obs_rdata}, 32'd0);
        chk("rst_pass_addr", {16'd0, obs_addr}, 32'h0000BEEF);
        chk("rst_pass_data", {24'd0, obs_data}, 32'h11);
        chk("rst_pass_strobes", {30'd0, obs_nwe, obs_noe}, 32'd2);

        // Halt only at an instruction boundary, exactly one cycle later
        dma_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("no_halt_mid_instr", {31'd0, obs_halt}, 32'd0);
        end
        ifn = 1'b0;
        chk("halt_not_early", {31'd0, obs_halt}, 32'd0);
        step();
        ifn = 1'b1;
        chk("halt_at_boundary", {31'd0, obs_halt}, 32'd1);
        chk("grant_at_boundary", {31'd0, obs_grant}, 32'd1);

        // One wait state: write 0xA5 to 0x1234
        access(1'b1, 16'h1234, 8'hA5, 1'b0, lat, nwe_lo, noe_lo);
        chk("w1_latency", lat, 32'd3);
        chk("w1_nwe_cycles", nwe_lo, 32'd1);
        chk("w1_noe_cycles", noe_lo, 32'd0);
        chk("w1_rdata_kept", {24'd0, obs_rdata}, 32'd0);
        dma_req = 1'b0;
        step();
        chk("w1_release", {30'd0, obs_halt, obs_grant}, 32'd0);

        // Three wait states: read 0x0042 holding 0x5A
        sel = 1'b1;
        do_reset();
        do_grant();
        access(1'b0, 16'h0042, 8'h00, 1'b0, lat, nwe_lo, noe_lo);
        chk("r3_latency", lat, 32'd5);
        chk("r3_noe_cycles", noe_lo, 32'd3);
        chk("r3_nwe_cycles", nwe_lo, 32'd0);
        chk("r3_rdata_held", {24'd0, obs_rdata}, 32'h5A);
        dma_req = 1'b0;
        step();
        chk("r3_release", {30'd0, obs_halt, obs_grant}, 32'd0);

        // Burst limit of four with continuous requests, then boundary-gated re-grant
        sel = 1'b0;
        do_reset();
        do_grant();
        dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 16'h0100;
        cyc = 0;
        while (obs_grant && cyc < 60) begin
            if (obs_ready) sb.push_back('{1'b0, ram_model(16'h0100)});
            step();
            cyc++;
        end
        dma_valid = 1'b0;
        chk("burst_dones", done_cnt, 32'd4);
        chk("burst_cycles", cyc, 32'd16);
        chk("burst_released", {31'd0, obs_halt}, 32'd0);
        chk("burst_sb_empty", sb.size(), 32'd0);
        ifn = 1'b0;
        step();
        chk("no_regrant_first_cpu", {31'd0, obs_halt}, 32'd0);
        ifn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_regrant_mid_instr", {31'd0, obs_halt}, 32'd0);
        end
        ifn = 1'b0;
        step();
        ifn = 1'b1;
        chk("regrant_at_boundary", {31'd0, obs_halt}, 32'd1);
        dma_req = 1'b0;
        step();
        chk("regrant_release", {31'd0, obs_grant}, 32'd0);

        // Request dropped during SETUP: access still completes, then CPU pass-through
        sel = 1'b1;
        do_reset();
        do_grant();
        cpu_nwe = 1'b0; cpu_addr = 16'hC0DE;
        access(1'b1, 16'h0300, 8'h77, 1'b1, lat, nwe_lo, noe_lo);
        chk("drop_latency", lat, 32'd5);
        chk("drop_nwe_cycles", nwe_lo, 32'd3);
        step();
        chk("drop_release", {30'd0, obs_halt, obs_grant}, 32'd0);
        chk("drop_pass_nwe", {31'd0, obs_nwe}, 32'd0);
        chk("drop_pass_addr", {16'd0, obs_addr}, 32'h0000C0DE);
        cpu_nwe = 1'b1; cpu_addr = 16'hBEEF;

        // Reset in the middle of a write strobe
        do_reset();
        do_grant();
        dma_write = 1'b1; dma_addr = 16'h0777; dma_wdata = 8'h3C; dma_valid = 1'b1;
        step();
        dma_valid = 1'b0;
        step();
        chk("mid_strobe_nwe_low", {31'd0, obs_nwe}, 32'd0);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_nwe", {31'd0, obs_nwe}, 32'd1);
        chk("rst_mid_halt", {31'd0, obs_halt}, 32'd0);
        chk("rst_mid_grant", {31'd0, obs_grant}, 32'd0);
        chk("rst_mid_done", {31'd0, obs_done}, 32'd0);
        chk("rst_mid_addr", {16'd0, obs_addr}, 32'h0000BEEF);
        dma_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_mid_no_done", done_cnt - d0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
